mips_multicycle_ctrl: RTL and testbench

//   Main control FSM for the multi-cycle MIPS datapath. Sequences the ALU, register file, PC and

---
 rtl/mips_multicycle_ctrl_pkg.sv | 60 ++++++
 rtl/mips_multicycle_ctrl_if.sv | 43 ++++
 rtl/mips_multicycle_ctrl_mem_wait_timer.sv | 32 +++
 rtl/mips_multicycle_ctrl.sv | 144 ++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LW_WB    = 4'd4,
    S_MEM_WR   = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ      = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath signal bundle. illegal_op exists only with ILLEGAL_OP_TRAP_EN.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       mem_timeout;
  logic [3:0] state_dbg;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       illegal_op;
`endif

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, mem_timeout, state_dbg
`ifdef ILLEGAL_OP_TRAP_EN
          , illegal_op
`endif
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, mem_timeout, state_dbg
`ifdef ILLEGAL_OP_TRAP_EN
          , illegal_op
`endif
  );
endinterface

// File: rtl/mips_multicycle_ctrl_mem_wait_timer.sv
// Memory wait counter with sticky overrun flag.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_active,   // FSM sits in a memory state this cycle
  input  logic i_ready,
  output logic o_timeout
);
  localparam int W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] r_cnt;
  logic         r_flag;
  logic         w_overrun;

  // Overrun is judged on the count alone so a late mem_ready still flags it.
  assign w_overrun = i_active && (r_cnt == LAST);
  assign o_timeout = r_flag || w_overrun;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_flag <= 1'b0;
    end else begin
      if (!i_active || i_ready || w_overrun) r_cnt <= '0;
      else                                   r_cnt <= r_cnt + W'(1);
      if (w_overrun) r_flag <= 1'b1;
    end
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM. Define ILLEGAL_OP_TRAP_EN to trap unknown opcodes.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   reset_n,
  mips_multicycle_ctrl_if.master bus
);
  state_e     r_state, w_next;
  logic [5:0] r_opcode;
  logic       r_run;
  ctrl_t      w_ctrl;
  logic       w_timeout;

  // r_run holds everything quiet from reset release until the first clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run    <= 1'b0;
      r_state  <= S_FETCH;
      r_opcode <= '0;
    end else begin
      r_run   <= 1'b1;
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= bus.opcode;
    end
  end

  always_comb begin
    w_next = r_state;
    if (r_run) begin
      case (r_state)
        S_FETCH:    if (bus.mem_ready) w_next = S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_RTYPE:     w_next = S_RTYPE_EX;
            OP_LW, OP_SW: w_next = S_MEM_ADDR;
            OP_BEQ:       w_next = S_BEQ;
            OP_ADDI:      w_next = S_ADDI_EX;
            OP_J:         w_next = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
            default:      w_next = S_TRAP;
`else
            default:      w_next = S_FETCH;
`endif
          endcase
        end
        S_MEM_ADDR: w_next = (r_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (bus.mem_ready) w_next = S_LW_WB;
        S_MEM_WR:   if (bus.mem_ready) w_next = S_FETCH;
        S_RTYPE_EX: w_next = S_RTYPE_WB;
        S_ADDI_EX:  w_next = S_ADDI_WB;
        S_TRAP:     w_next = S_TRAP;
        default:    w_next = S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.ir_write  = bus.mem_ready;
        w_ctrl.pc_write  = bus.mem_ready;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        w_ctrl.alu_src_b = SRCB_IMM_SH;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
      end
      S_LW_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.i_or_d    = 1'b1;
      end
      S_RTYPE_EX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_RT;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = SRCB_RT;
        w_ctrl.alu_op        = ALUOP_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_ADDI_WB: w_ctrl.reg_write = 1'b1;
      S_JUMP: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCSRC_JUMP;
      end
      default: w_ctrl = '0;
    endcase
    if (!r_run) w_ctrl = '0;
  end

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_active  (r_run && is_mem_state(r_state)),
    .i_ready   (bus.mem_ready),
    .o_timeout (w_timeout)
  );

  assign bus.pc_write      = w_ctrl.pc_write;
  assign bus.pc_write_cond = w_ctrl.pc_write_cond;
  assign bus.i_or_d        = w_ctrl.i_or_d;
  assign bus.mem_read      = w_ctrl.mem_read;
  assign bus.mem_write     = w_ctrl.mem_write;
  assign bus.ir_write      = w_ctrl.ir_write;
  assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
  assign bus.reg_dst       = w_ctrl.reg_dst;
  assign bus.reg_write     = w_ctrl.reg_write;
  assign bus.alu_src_a     = w_ctrl.alu_src_a;
  assign bus.alu_src_b     = w_ctrl.alu_src_b;
  assign bus.alu_op        = w_ctrl.alu_op;
  assign bus.pc_source     = w_ctrl.pc_source;
  assign bus.mem_timeout   = w_timeout;
  assign bus.state_dbg     = r_state;
`ifdef ILLEGAL_OP_TRAP_EN
  assign bus.illegal_op    = r_run && (r_state == S_TRAP);
`endif
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl with a per-cycle expectation queue.
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus();
  mips_multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
  logic [15:0] obs;
  assign obs = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source};

  localparam logic [15:0] Z   = 16'h0000;
  localparam logic [15:0] F1  = 16'b1_0_0_1_0_1_0_0_0_0_01_00_00;
  localparam logic [15:0] F0  = 16'b0_0_0_1_0_0_0_0_0_0_01_00_00;
  localparam logic [15:0] DEC = 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [15:0] MAD = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [15:0] MRD = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
  localparam logic [15:0] LWB = 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [15:0] MWR = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
  localparam logic [15:0] REX = 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [15:0] RWB = 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
  localparam logic [15:0] BQ  = 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [15:0] AEX = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [15:0] AWB = 16'b0_0_0_0_0_0_0_0_1_0_00_00_00;
  localparam logic [15:0] JMP = 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BE = 6'b000100, AD = 6'b001000, JP = 6'b000010, BAD = 6'b111111;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] v;
    logic        tmo;
    logic        ill;
  } exp_t;

  exp_t  q[$];
  string tq[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge: drive, queue expectation, compare at the falling edge.
  task automatic cyc(input bit rdy, input logic [5:0] op, input logic [3:0] st,
                     input logic [15:0] v, input bit tmo, input bit ill,
                     input string tag, input bit rst = 1'b0);
    exp_t  e;
    string t;
    bus.mem_ready = rdy;
    bus.opcode    = op;
    if (rst) begin
      #1 reset_n = 1'b0;
    end
    q.push_back('{st: st, v: v, tmo: tmo, ill: ill});
    tq.push_back(tag);
    @(negedge clk);
    e = q.pop_front();
    t = tq.pop_front();
    chk({t, ".state"}, {12'd0, bus.state_dbg}, {12'd0, e.st});
    chk({t, ".ctrl"}, obs, e.v);
    chk({t, ".timeout"}, {15'd0, bus.mem_timeout}, {15'd0, e.tmo});
`ifdef ILLEGAL_OP_TRAP_EN
    chk({t, ".illegal"}, {15'd0, bus.illegal_op}, {15'd0, e.ill});
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode    = RT;
    @(posedge clk); #1;
    cyc(1, RT, 0, Z, 0, 0, "reset_hold0");
    cyc(1, RT, 0, Z, 0, 0, "reset_hold1");
    reset_n = 1'b1;
    cyc(1, RT, 0, Z, 0, 0, "release_quiet");

    // R-type: 0,1,6,7
    cyc(1, RT, 0, F1,  0, 0, "rt_fetch");
    cyc(1, RT, 1, DEC, 0, 0, "rt_decode");
    cyc(1, RT, 6, REX, 0, 0, "rt_ex");
    cyc(1, RT, 7, RWB, 0, 0, "rt_wb");

    // lw with three stall cycles; live opcode changed after DECODE
    cyc(1, LW, 0, F1,  0, 0, "lw_fetch");
    cyc(1, LW, 1, DEC, 0, 0, "lw_decode");
    cyc(1, SW, 2, MAD, 0, 0, "lw_addr");
    for (int i = 0; i < 3; i++) cyc(0, SW, 3, MRD, 0, 0, "lw_rd_stall");
    cyc(1, SW, 3, MRD, 0, 0, "lw_rd_done");
    cyc(1, SW, 4, LWB, 0, 0, "lw_wb");

    // sw
    cyc(1, SW, 0, F1,  0, 0, "sw_fetch");
    cyc(1, SW, 1, DEC, 0, 0, "sw_decode");
    cyc(1, LW, 2, MAD, 0, 0, "sw_addr");
    cyc(1, LW, 5, MWR, 0, 0, "sw_wr");

    // beq, addi, j
    cyc(1, BE, 0, F1,  0, 0, "beq_fetch");
    cyc(1, BE, 1, DEC, 0, 0, "beq_decode");
    cyc(1, BE, 8, BQ,  0, 0, "beq_exec");
    cyc(1, AD, 0, F1,  0, 0, "addi_fetch");
    cyc(1, AD, 1, DEC, 0, 0, "addi_decode");
    cyc(1, AD, 9, AEX, 0, 0, "addi_ex");
    cyc(1, AD, 10, AWB, 0, 0, "addi_wb");
    cyc(1, JP, 0, F1,  0, 0, "j_fetch");
    cyc(1, JP, 1, DEC, 0, 0, "j_decode");
    cyc(1, JP, 11, JMP, 0, 0, "j_jump");

    // mem_ready on the overrun cycle: transition taken and timeout set
    cyc(1, LW, 0, F1,  0, 0, "ovr_fetch");
    cyc(1, LW, 1, DEC, 0, 0, "ovr_decode");
    cyc(1, LW, 2, MAD, 0, 0, "ovr_addr");
    for (int i = 0; i < 15; i++) cyc(0, LW, 3, MRD, 0, 0, "ovr_wait");
    cyc(1, LW, 3, MRD, 1, 0, "ovr_ready_same_cycle");
    cyc(1, LW, 4, LWB, 1, 0, "ovr_wb_sticky");

    // reset asserted during MEM_WR with mem_ready high
    cyc(1, SW, 0, F1,  1, 0, "abort_fetch");
    cyc(1, SW, 1, DEC, 1, 0, "abort_decode");
    cyc(1, SW, 2, MAD, 1, 0, "abort_addr");
    cyc(0, SW, 5, MWR, 1, 0, "abort_wr_wait");
    cyc(1, SW, 0, Z,   0, 0, "abort_reset", 1'b1);
    cyc(1, SW, 0, Z,   0, 0, "abort_reset_hold");
    reset_n = 1'b1;
    cyc(0, JP, 0, Z,   0, 0, "abort_release_quiet");

    // FETCH timeout: rises on the 16th waiting cycle, then sticky
    for (int k = 1; k <= 18; k++) cyc(0, JP, 0, F0, (k >= 16), 0, "fetch_timeout");
    cyc(1, JP, 0, F1,  1, 0, "to_fetch_done");
    cyc(1, JP, 1, DEC, 1, 0, "to_decode");
    cyc(1, JP, 11, JMP, 1, 0, "to_jump");

    // unknown opcode
    cyc(1, BAD, 0, F1,  1, 0, "ill_fetch");
    cyc(1, BAD, 1, DEC, 1, 0, "ill_decode");
`ifdef ILLEGAL_OP_TRAP_EN
    for (int i = 0; i < 3; i++) cyc(1, RT, 12, Z, 1, 1, "ill_trap");
`else
    cyc(1, RT, 0, F1,  1, 0, "ill_nop_fetch");
    cyc(1, RT, 1, DEC, 1, 0, "ill_nop_decode");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
